// File: rtl/rr_arb_pkg.sv
// Shared constants and types for the 4-way round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rr_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  // EMPTY: no word held; FULL: word held, free arbitration;
  // LOCKED: a multi-beat burst owns the channel until its last beat.
  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    FULL   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Pointer starts at the top index so requester 0 is searched first.
  localparam logic [SEL_W-1:0] PTR_RST = 2'd3;

  // One-hot grant vector for a requester index.
  function automatic logic [NUM_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux4_1_param.sv
// Parameterised 4-to-1 word select.
// Latency: combinational, 0 cycles.
// Backpressure: none; pure select.
module mux4_1_param #(
  parameter int N = 4
) (
  input  logic [1:0]   i_sel,
  input  logic [N-1:0] i_d0,
  input  logic [N-1:0] i_d1,
  input  logic [N-1:0] i_d2,
  input  logic [N-1:0] i_d3,
  output logic [N-1:0] o_y
);

  // Route the indexed input word to the output.
  always_comb begin
    o_y = i_d0;
    case (i_sel)
      2'd0:    o_y = i_d0;
      2'd1:    o_y = i_d1;
      2'd2:    o_y = i_d2;
      default: o_y = i_d3;
    endcase
  end

endmodule

// File: rtl/rr_pick4.sv
// Round-robin winner search over 4 requesters, starting after the pointer.
// Latency: combinational, 0 cycles.
// Backpressure: none; the caller decides whether the winner is granted.
module rr_pick4
  import rr_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req_valid,
  input  logic [SEL_W-1:0]   i_ptr,
  output logic [SEL_W-1:0]   o_winner,
  output logic               o_any
);

  logic [SEL_W-1:0] w_idx;
  logic             w_found;

  // Walk ptr+1, ptr+2, ptr+3, ptr (mod 4) and keep the first valid index.
  always_comb begin
    o_winner = '0;
    o_any    = |i_req_valid;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = i_ptr + SEL_W'(k);
      if (!w_found && i_req_valid[w_idx]) begin
        o_winner = w_idx;
        w_found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter4.sv
// Round-robin arbiter sharing one N-bit channel among 4 requesters, with a
// one-entry registered output stage. Latency: 1 cycle handshake-to-out_valid.
// Backpressure: req_ready only when the output stage is empty or retiring.
// Optional burst lock: define RR_MUX_ARBITER4_LOCK_EN to add req_last and the
// LOCKED state, which keeps the channel on one requester until its last beat.
module rr_mux_arbiter4
  import rr_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [N-1:0]       req_data0,
  input  logic [N-1:0]       req_data1,
  input  logic [N-1:0]       req_data2,
  input  logic [N-1:0]       req_data3,
`ifdef RR_MUX_ARBITER4_LOCK_EN
  input  logic [NUM_REQ-1:0] req_last,
`endif
  output logic [NUM_REQ-1:0] req_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       out_data,
  output logic [SEL_W-1:0]   out_sel
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_out_valid;
  logic [N-1:0]     r_out_data;
  logic [SEL_W-1:0] r_out_sel;
  logic [SEL_W-1:0] r_ptr;

  logic [SEL_W-1:0] w_pick_winner;
  logic             w_pick_any;
  logic [SEL_W-1:0] w_winner;
  logic             w_any;
  logic             w_load;
  logic             w_grant;
  logic [N-1:0]     w_mux_dat;

  rr_pick4 u_pick (
    .i_req_valid (req_valid),
    .i_ptr       (r_ptr),
    .o_winner    (w_pick_winner),
    .o_any       (w_pick_any)
  );

  mux4_1_param #(.N(N)) u_mux (
    .i_sel (w_winner),
    .i_d0  (req_data0),
    .i_d1  (req_data1),
    .i_d2  (req_data2),
    .i_d3  (req_data3),
    .o_y   (w_mux_dat)
  );

  // Effective winner: the round-robin pick, or the burst owner while locked.
  always_comb begin
    w_winner = w_pick_winner;
    w_any    = w_pick_any;
`ifdef RR_MUX_ARBITER4_LOCK_EN
    if (r_state == LOCKED) begin
      // out_sel always names the last granted requester, i.e. the owner.
      w_winner = r_out_sel;
      w_any    = req_valid[r_out_sel];
    end
`endif
    w_load  = !r_out_valid || out_ready;
    w_grant = w_load && w_any && !rst;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state: only a load slot can change the state.
  always_comb begin
    w_state_nxt = r_state;
    if (w_load) begin
`ifdef RR_MUX_ARBITER4_LOCK_EN
      if (w_any) begin
        w_state_nxt = req_last[w_winner] ? FULL : LOCKED;
      end else if (r_state != LOCKED) begin
        w_state_nxt = EMPTY;
      end
`else
      w_state_nxt = w_any ? FULL : EMPTY;
`endif
    end
  end

  // FSM outputs: one-hot grant and the registered output stage.
  always_comb begin
    req_ready = w_grant ? onehot4(w_winner) : '0;
    out_valid = r_out_valid;
    out_data  = r_out_data;
    out_sel   = r_out_sel;
  end

  // Output stage and pointer: load on a free slot, freeze while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_ptr       <= PTR_RST;
    end else if (w_load) begin
      r_out_valid <= w_any;
      if (w_any) begin
        r_out_data <= w_mux_dat;
        r_out_sel  <= w_winner;
        r_ptr      <= w_winner;
      end
    end
  end

endmodule
